cpu_sequencer: RTL and testbench

// - Drives the instruction decoder: owns the 2-bit state machine, instruction register (IR), PC, stack pointer and status register.
// - Consumes the decoder's control strobes and feeds back state, instruction, status_reg and stack_overflow.
// - Sits between the instruction RAM and the decoder, one per CPU core.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/stack_pointer.sv | 40 ++++
 rtl/cpu_sequencer.sv | 86 ++++++++
 tb/tb_cpu_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings and widths for the CPU sequencer
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC1 = 2'b10,
        ST_EXEC2 = 2'b01,
        ST_HALT  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        JS_REG    = 2'b00,
        JS_DIRECT = 2'b01,
        JS_RET    = 2'b10
    } jump_sel_e;

    localparam int INSTR_W = 16;
    localparam int FLAG_W  = 8;

endpackage

// File: rtl/stack_pointer.sv
// stack_pointer: saturating stack pointer with sticky overflow flag
module stack_pointer #(
    parameter int SP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            push,
    input  logic            pop,
    output logic [SP_W-1:0] sp,
    output logic            overflow
);

    logic [SP_W-1:0] sp_d, sp_q;
    logic            ovf_d, ovf_q;
    logic            do_push, do_pop;

    // push and pop together cancel; push at full saturates and flags, pop at empty holds
    always_comb begin
        do_push = en & push & ~pop;
        do_pop  = en & pop & ~push;
        sp_d    = (do_push && !(&sp_q)) ? sp_q + 1'b1 : (do_pop && |sp_q) ? sp_q - 1'b1 : sp_q;
        ovf_d   = ovf_q | (do_push & (&sp_q));
    end

    // pointer and sticky flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
        end
    end

    assign sp       = sp_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction sequencing FSM with IR, PC, stack pointer and status register
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          SP_W     = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr_rdata,
    input  logic               sm_extra,
    input  logic               stop,
    input  logic               pc_sload,
    input  logic               pc_cnt_en,
    input  logic [1:0]         jump_sel,
    input  logic [ADDR_W-1:0]  reg_target,
    input  logic [ADDR_W-1:0]  ret_addr,
    input  logic               stack_reg_increment,
    input  logic               stack_reg_load,
    input  logic               status_reg_sload,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic [1:0]         state,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic [SP_W-1:0]    sp,
    output logic [FLAG_W-1:0]  status_reg,
    output logic               stack_overflow,
    output logic               halted
);

    state_e             state_d, state_q;
    logic [INSTR_W-1:0] ir_d, ir_q;
    logic [ADDR_W-1:0]  pc_d, pc_q, jump_target;
    logic [FLAG_W-1:0]  status_d, status_q;
    logic               active;

    assign active = state_q != ST_HALT;

    // next state, IR capture, PC jump/increment and status capture; everything frozen in HALT
    always_comb begin
        jump_target = (jump_sel == JS_DIRECT) ? ir_q[ADDR_W-1:0] : (jump_sel == JS_RET) ? ret_addr : reg_target;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC1;
            ST_EXEC1: state_d = stop ? ST_HALT : sm_extra ? ST_EXEC2 : ST_FETCH;
            ST_EXEC2: state_d = ST_FETCH;
            default:  state_d = run ? ST_FETCH : ST_HALT;
        endcase
        ir_d     = (state_q == ST_FETCH) ? instr_rdata : ir_q;
        pc_d     = !active ? pc_q : pc_sload ? jump_target : pc_cnt_en ? pc_q + 1'b1 : pc_q;
        status_d = (active && status_reg_sload) ? alu_flags : status_q;
    end

    // FSM, IR, PC and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            pc_q     <= ADDR_W'(RESET_PC);
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            status_q <= status_d;
        end
    end

    stack_pointer #(.SP_W(SP_W)) u_stack_pointer (
        .clk      (clk),
        .reset    (reset),
        .en       (active),
        .push     (stack_reg_increment),
        .pop      (stack_reg_load),
        .sp       (sp),
        .overflow (stack_overflow)
    );

    assign state       = state_q;
    assign instruction = ir_q;
    assign pc_addr     = pc_q;
    assign status_reg  = status_q;
    assign halted      = state_q == ST_HALT;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, run, sm_extra, stop, pc_sload, pc_cnt_en;
    logic        stack_reg_increment, stack_reg_load, status_reg_sload;
    logic [15:0] instr_rdata;
    logic [1:0]  jump_sel;
    logic [9:0]  reg_target, ret_addr;
    logic [7:0]  alu_flags;
    logic [1:0]  state;
    logic [15:0] instruction;
    logic [9:0]  pc_addr;
    logic [3:0]  sp;
    logic [7:0]  status_reg;
    logic        stack_overflow, halted;

    typedef struct {
        logic [1:0]  st;
        logic [9:0]  pc;
        logic [15:0] ir;
        logic [3:0]  sp;
        logic [7:0]  sr;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0]  m_st;
    logic [9:0]  m_pc, m_tgt;
    logic [15:0] m_ir;
    logic [3:0]  m_sp;
    logic [7:0]  m_sr;
    logic        m_ovf;
    int          n_chk = 0;
    int          n_err = 0;

    cpu_sequencer #(.ADDR_W(10), .SP_W(4), .RESET_PC(0)) dut (
        .clk                 (clk),
        .reset               (reset),
        .run                 (run),
        .instr_rdata         (instr_rdata),
        .sm_extra            (sm_extra),
        .stop                (stop),
        .pc_sload            (pc_sload),
        .pc_cnt_en           (pc_cnt_en),
        .jump_sel            (jump_sel),
        .reg_target          (reg_target),
        .ret_addr            (ret_addr),
        .stack_reg_increment (stack_reg_increment),
        .stack_reg_load      (stack_reg_load),
        .status_reg_sload    (status_reg_sload),
        .alu_flags           (alu_flags),
        .state               (state),
        .instruction         (instruction),
        .pc_addr             (pc_addr),
        .sp                  (sp),
        .status_reg          (status_reg),
        .stack_overflow      (stack_overflow),
        .halted              (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        {run, sm_extra, stop, pc_sload, pc_cnt_en} = '0;
        {stack_reg_increment, stack_reg_load, status_reg_sload} = '0;
        jump_sel = 2'b00;
    endtask

    // advance the reference model one clock, push its prediction, then compare after the edge
    task automatic cyc();
        exp_t e;
        if (reset) begin
            m_st = ST_FETCH; m_pc = '0; m_ir = '0; m_sp = '0; m_sr = '0; m_ovf = 1'b0;
        end else if (m_st == ST_HALT) begin
            if (run) m_st = ST_FETCH;
        end else begin
            case (jump_sel)
                2'b01:   m_tgt = m_ir[9:0];
                2'b10:   m_tgt = ret_addr;
                default: m_tgt = reg_target;
            endcase
            if (pc_sload) m_pc = m_tgt;
            else if (pc_cnt_en) m_pc = m_pc + 10'd1;
            if (stack_reg_increment && !stack_reg_load) begin
                if (m_sp == 4'd15) m_ovf = 1'b1;
                else m_sp = m_sp + 4'd1;
            end else if (stack_reg_load && !stack_reg_increment && m_sp != 4'd0) begin
                m_sp = m_sp - 4'd1;
            end
            if (status_reg_sload) m_sr = alu_flags;
            if (m_st == ST_FETCH) begin
                m_ir = instr_rdata;
                m_st = ST_EXEC1;
            end else if (m_st == ST_EXEC1) begin
                m_st = stop ? ST_HALT : sm_extra ? ST_EXEC2 : ST_FETCH;
            end else begin
                m_st = ST_FETCH;
            end
        end
        e = '{st: m_st, pc: m_pc, ir: m_ir, sp: m_sp, sr: m_sr, ovf: m_ovf};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("state", state, e.st);
        check("pc", pc_addr, e.pc);
        check("ir", instruction, e.ir);
        check("sp", sp, e.sp);
        check("status", status_reg, e.sr);
        check("ovf", stack_overflow, e.ovf);
        check("halted", halted, e.st == ST_HALT);
    endtask

    // cycle until the DUT reaches the wanted state, with a small budget
    task automatic go_to(input logic [1:0] target);
        for (int i = 0; i < 6 && m_st != target; i++) cyc();
        check("reach", state, target);
    endtask

    initial begin
        logic [9:0] pc_hold;
        logic [7:0] sr_hold;
        clear_inputs();
        reset = 1'b1;
        instr_rdata = 16'h0000;
        reg_target = '0;
        ret_addr = '0;
        alu_flags = '0;
        m_st = ST_FETCH; m_pc = '0; m_ir = '0; m_sp = '0; m_sr = '0; m_ovf = 1'b0;
        cyc();
        check("rst_state", state, 2'b00);
        check("rst_pc", pc_addr, 10'h000);
        reset = 1'b0;

        instr_rdata = 16'hBEEF;
        cyc();
        check("s1", state, 2'b10);
        check("ir_fetch", instruction, 16'hBEEF);
        cyc();
        check("s2", state, 2'b00);
        cyc();
        check("s3", state, 2'b10);
        check("pc_idle", pc_addr, 10'h000);

        go_to(ST_FETCH);
        pc_sload = 1'b1; reg_target = 10'h3FF;
        cyc();
        check("pc_load", pc_addr, 10'h3FF);
        clear_inputs();
        go_to(ST_FETCH);
        pc_cnt_en = 1'b1;
        cyc();
        check("pc_wrap", pc_addr, 10'h000);
        clear_inputs();

        go_to(ST_FETCH);
        instr_rdata = 16'hA955;
        cyc();
        sm_extra = 1'b1; pc_sload = 1'b1; jump_sel = 2'b01; reg_target = 10'h2AA;
        cyc();
        check("exec2", state, 2'b01);
        check("pc_direct", pc_addr, 10'h155);
        clear_inputs();
        cyc();
        check("exec2_ret", state, 2'b00);

        stack_reg_increment = 1'b1;
        for (int i = 0; i < 15; i++) cyc();
        check("sp15", sp, 4'd15);
        check("ovf_pre", stack_overflow, 1'b0);
        cyc();
        check("ovf_16", stack_overflow, 1'b1);
        cyc();
        check("sp_sat", sp, 4'd15);
        stack_reg_load = 1'b1;
        cyc();
        check("sp_both", sp, 4'd15);
        stack_reg_increment = 1'b0;
        for (int i = 0; i < 16; i++) cyc();
        check("sp_floor", sp, 4'd0);
        check("ovf_sticky", stack_overflow, 1'b1);
        clear_inputs();

        go_to(ST_EXEC1);
        stop = 1'b1; sm_extra = 1'b1;
        cyc();
        check("halt", state, 2'b11);
        pc_hold = pc_addr;
        sr_hold = status_reg;
        clear_inputs();
        pc_cnt_en = 1'b1; status_reg_sload = 1'b1; alu_flags = 8'h3C; stack_reg_increment = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check("halt_pc", pc_addr, pc_hold);
        check("halt_sr", status_reg, sr_hold);
        check("halt_hold", halted, 1'b1);
        clear_inputs();
        run = 1'b1;
        cyc();
        check("run", state, 2'b00);
        cyc();
        check("run_ignored", state, 2'b10);
        run = 1'b0;

        status_reg_sload = 1'b1; alu_flags = 8'hA5;
        cyc();
        check("status", status_reg, 8'hA5);
        clear_inputs();
        go_to(ST_EXEC1);
        sm_extra = 1'b1;
        cyc();
        check("pre_rst", state, 2'b01);
        clear_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst2_state", state, 2'b00);
        check("rst2_ir", instruction, 16'h0000);
        check("rst2_sr", status_reg, 8'h00);
        check("rst2_ovf", stack_overflow, 1'b0);

        for (int i = 0; i < 80; i++) begin
            {sm_extra, pc_sload, pc_cnt_en, stack_reg_increment, stack_reg_load, status_reg_sload} = 6'($urandom);
            stop = ($urandom_range(7) == 0);
            run = ($urandom_range(2) == 0);
            reset = ($urandom_range(39) == 0);
            jump_sel = 2'($urandom);
            instr_rdata = 16'($urandom);
            reg_target = 10'($urandom);
            ret_addr = 10'($urandom);
            alu_flags = 8'($urandom);
            cyc();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
